// File: rtl/rx_phase_slicer_pkg.sv
// ---------------------------------------------------------------------------
// rx_phase_slicer_pkg
//   Shared definitions for the receive phase slicer: default widths, FSM
//   state type and the bit/sign convention used by the slicer.
// ---------------------------------------------------------------------------
package rx_phase_slicer_pkg;

  localparam int unsigned DEF_NB_INPUT    = 13;
  localparam int unsigned DEF_OVER_SAMP   = 8;
  localparam int unsigned DEF_NB_COUNT    = 3;
  localparam int unsigned DEF_NB_ENERGY   = 24;
  localparam int unsigned DEF_WINDOW_LOG2 = 10;

  // A recovered '1' corresponds to a negative sample (BPSK mapping of the TX side).
  localparam bit BIT_ONE_IS_NEG = 1'b1;

  typedef enum logic {
    S_ACQ   = 1'b0,
    S_TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/rx_phase_slicer_argmax.sv
// ---------------------------------------------------------------------------
// phase_argmax
//   Combinational selection of the largest per-phase energy.
//   Ties resolve to the lowest phase index.
//   i_acc : OVER_SAMP packed energies, phase 0 in the least significant slot
//   o_idx : index of the (first) maximum
// ---------------------------------------------------------------------------
module phase_argmax
  import rx_phase_slicer_pkg::*;
#(
  parameter int unsigned OVER_SAMP = DEF_OVER_SAMP,
  parameter int unsigned NB_COUNT  = DEF_NB_COUNT,
  parameter int unsigned NB_ENERGY = DEF_NB_ENERGY
) (
  input  logic [OVER_SAMP*NB_ENERGY-1:0] i_acc,
  output logic [NB_COUNT-1:0]            o_idx
);

  logic [NB_ENERGY-1:0] w_best_val;
  logic [NB_COUNT-1:0]  w_best_idx;

  // Strict '>' keeps the earlier (lower) index when values are equal.
  always_comb begin
    w_best_val = i_acc[NB_ENERGY-1:0];
    w_best_idx = '0;
    for (int unsigned i = 1; i < OVER_SAMP; i++) begin
      if (i_acc[i*NB_ENERGY +: NB_ENERGY] > w_best_val) begin
        w_best_val = i_acc[i*NB_ENERGY +: NB_ENERGY];
        w_best_idx = NB_COUNT'(i);
      end
    end
  end

  assign o_idx = w_best_idx;

endmodule

// File: rtl/rx_phase_slicer.sv
// ---------------------------------------------------------------------------
// rx_phase_slicer
//   Receive counterpart of the polyphase BPSK TX FIR. Accumulates |sample|
//   per oversampling phase over a window of 2**WINDOW_LOG2 symbols, picks the
//   strongest phase at each window end, then decimates to one sample per
//   symbol and slices its sign into a bit.
//   clk       : system clock, rising edge
//   i_rst_n   : asynchronous reset, active low
//   i_enable  : block enable, all state holds when low
//   i_valid   : i_data carries a sample
//   i_data    : signed sample
//   o_bit     : recovered bit (1 = negative sample)
//   o_valid   : one-cycle strobe, o_bit is new
//   o_phase   : selected sampling phase
//   o_lock    : high once the first window has completed
// ---------------------------------------------------------------------------
module rx_phase_slicer
  import rx_phase_slicer_pkg::*;
#(
  parameter int unsigned NB_INPUT    = DEF_NB_INPUT,
  parameter int unsigned OVER_SAMP   = DEF_OVER_SAMP,
  parameter int unsigned NB_COUNT    = DEF_NB_COUNT,
  parameter int unsigned NB_ENERGY   = DEF_NB_ENERGY,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [NB_INPUT-1:0] i_data,
  output logic                o_bit,
  output logic                o_valid,
  output logic [NB_COUNT-1:0] o_phase,
  output logic                o_lock
);

  localparam logic [NB_COUNT-1:0] LAST_PHASE = NB_COUNT'(OVER_SAMP - 1);
  localparam int unsigned         NB_SUM     = NB_ENERGY + 1;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [NB_COUNT-1:0]            r_phase_cnt;
  logic [WINDOW_LOG2-1:0]         r_sym_cnt;
  logic [NB_COUNT-1:0]            r_phase;
  logic                           r_bit;
  logic                           r_valid;

  logic                           w_s;
  logic                           w_win_end;
  logic                           w_decide;
  logic                           w_slice;
  logic [NB_INPUT-1:0]            w_mag_full;
  logic [NB_INPUT-2:0]            w_abs;
  logic [OVER_SAMP*NB_ENERGY-1:0] w_acc_post;
  logic [NB_COUNT-1:0]            w_best;

  assign w_s       = i_enable & i_valid;
  assign w_win_end = w_s && (r_phase_cnt == LAST_PHASE) && (r_sym_cnt == '1);

  always_comb begin
    w_mag_full = i_data;
    if (i_data[NB_INPUT-1]) begin
      w_mag_full = ~i_data + NB_INPUT'(1);
    end
  end

  // Only the most negative input negates to a value with the top bit set; clamp it.
  assign w_abs   = w_mag_full[NB_INPUT-1] ? '1 : w_mag_full[NB_INPUT-2:0];
  assign w_slice = BIT_ONE_IS_NEG ? i_data[NB_INPUT-1] : ~i_data[NB_INPUT-1];

  // Per-phase saturating energy accumulators. w_acc_post carries the value
  // including the current sample so the window-end argmax sees the final add.
  for (genvar g = 0; g < OVER_SAMP; g++) begin : gen_acc
    logic [NB_ENERGY-1:0] r_acc;
    logic [NB_SUM-1:0]    w_sum;
    logic                 w_hit;

    assign w_hit = w_s && (r_phase_cnt == NB_COUNT'(g));
    assign w_sum = {1'b0, r_acc} + NB_SUM'(w_abs);
    assign w_acc_post[g*NB_ENERGY +: NB_ENERGY] =
      !w_hit ? r_acc : (w_sum[NB_ENERGY] ? '1 : w_sum[NB_ENERGY-1:0]);

    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_acc <= '0;
      end else if (w_win_end) begin
        r_acc <= '0;
      end else if (w_hit) begin
        r_acc <= w_acc_post[g*NB_ENERGY +: NB_ENERGY];
      end
    end
  end

  phase_argmax #(
    .OVER_SAMP (OVER_SAMP),
    .NB_COUNT  (NB_COUNT),
    .NB_ENERGY (NB_ENERGY)
  ) u_argmax (
    .i_acc (w_acc_post),
    .o_idx (w_best)
  );

  // Decision compares against the registered phase, so a window end that
  // coincides with a decision still uses the old phase; the new phase only
  // takes effect from the following symbol.
  always_comb begin
    w_state_next = r_state;
    w_decide     = 1'b0;
    if (r_state == S_ACQ) begin
      if (w_win_end) begin
        w_state_next = S_TRACK;
      end
    end else begin
      w_decide = w_s && (r_phase_cnt == r_phase);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_ACQ;
      r_phase_cnt <= '0;
      r_sym_cnt   <= '0;
      r_phase     <= '0;
      r_bit       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_decide;
      if (w_decide) begin
        r_bit <= w_slice;
      end
      if (w_s) begin
        r_phase_cnt <= (r_phase_cnt == LAST_PHASE) ? '0 : r_phase_cnt + NB_COUNT'(1);
        if (r_phase_cnt == LAST_PHASE) begin
          r_sym_cnt <= r_sym_cnt + WINDOW_LOG2'(1);
        end
      end
      if (w_win_end) begin
        r_phase <= w_best;
      end
    end
  end

  assign o_bit   = r_bit;
  assign o_valid = r_valid;
  assign o_phase = r_phase;
  assign o_lock  = (r_state == S_TRACK);

endmodule

// File: tb/tb_rx_phase_slicer.sv
// ---------------------------------------------------------------------------
// tb_rx_phase_slicer
//   Randomised bench for rx_phase_slicer (WINDOW_LOG2=4, NB_ENERGY=14).
//   A sample-count based model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_rx_phase_slicer;

  localparam int     OS   = 8;
  localparam int     WIN  = 16;
  localparam int     NBE  = 14;
  localparam longint EMAX = (64'd1 << NBE) - 1;

  logic        clk      = 1'b0;
  logic        i_rst_n  = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_valid  = 1'b0;
  logic [12:0] i_data   = '0;
  logic        o_bit;
  logic        o_valid;
  logic [2:0]  o_phase;
  logic        o_lock;

  always #5 clk = ~clk;

  rx_phase_slicer #(
    .NB_INPUT    (13),
    .OVER_SAMP   (8),
    .NB_COUNT    (3),
    .NB_ENERGY   (NBE),
    .WINDOW_LOG2 (4)
  ) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_bit    (o_bit),
    .o_valid  (o_valid),
    .o_phase  (o_phase),
    .o_lock   (o_lock)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_n = 0;                 // accepted samples since reset
  longint      m_e[OS] = '{default: 0};
  int          m_phase = 0;
  bit          m_lock = 1'b0, m_valid = 1'b0, m_bit = 1'b0;
  bit          cur_tx_bit = 1'b0, last_tx_bit = 1'b0;

  function automatic longint mag(input logic [12:0] x);
    int v;
    v = int'($signed(x));
    if (v == -4096) return 4095;
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk or negedge i_rst_n) begin
    int     ph, sym, best;
    bit     dec;
    longint sum;
    if (!i_rst_n) begin
      m_n = 0;
      foreach (m_e[i]) m_e[i] = 0;
      m_phase = 0; m_lock = 1'b0; m_valid = 1'b0; m_bit = 1'b0;
    end else if (i_enable && i_valid) begin
      ph  = int'(m_n % OS);
      sym = int'((m_n / OS) % WIN);
      dec = m_lock && (ph == m_phase);
      sum = m_e[ph] + mag(i_data);
      m_e[ph] = (sum > EMAX) ? EMAX : sum;
      if (ph == OS - 1 && sym == WIN - 1) begin
        best = 0;
        for (int i = 1; i < OS; i++) if (m_e[i] > m_e[best]) best = i;
        m_phase = best;
        foreach (m_e[i]) m_e[i] = 0;
        m_lock = 1'b1;
      end
      m_valid = dec;
      if (dec) m_bit = ($signed(i_data) < 0);
      last_tx_bit = cur_tx_bit;
      m_n++;
    end else begin
      m_valid = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  bit loop_on = 1'b0, cnt_on = 1'b0;
  int loop_bits = 0, loop_errs = 0, vcnt = 0;

  always @(negedge clk) begin
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_bit",   32'(o_bit),   32'(m_bit));
    chk("o_phase", 32'(o_phase), 32'(m_phase));
    chk("o_lock",  32'(o_lock),  32'(m_lock));
    if (cnt_on && o_valid) vcnt++;
    if (loop_on && o_valid) begin
      loop_bits++;
      if (o_bit !== last_tx_bit) loop_errs++;
    end
  end

  // ---------------- stimulus ----------------
  int gap_max = 0;
  int shp[OS];
  logic [6:0] prbs = 7'h7F;

  task automatic tick(input bit en, input bit v, input logic [12:0] x);
    i_enable = en; i_valid = v; i_data = x;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic sample(input int val);
    int g;
    bit en;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      en = 1'($urandom_range(1, 0));
      tick(en, en ? 1'b0 : 1'($urandom_range(1, 0)), 13'($urandom));
    end
    tick(1'b1, 1'b1, 13'(val));
  endtask

  task automatic send_sym(input bit b, input int noise);
    int v;
    cur_tx_bit = b;
    for (int ph = 0; ph < OS; ph++) begin
      v = shp[ph];
      if (noise > 0) v = v + int'($urandom_range(2 * noise, 0)) - noise;
      sample(b ? -v : v);
    end
  endtask

  task automatic send_win(input int noise);
    repeat (WIN) send_sym(1'($urandom_range(1, 0)), noise);
  endtask

  function automatic bit prbs_next();
    bit nb;
    nb = prbs[6] ^ prbs[5];
    prbs = {prbs[5:0], nb};
    return nb;
  endfunction

  initial begin
    // Reset held while samples are offered
    repeat (4) tick(1'b1, 1'b1, 13'($urandom));
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_bit",   32'(o_bit),   0);
    chk("rst_phase", 32'(o_phase), 0);
    chk("rst_lock",  32'(o_lock),  0);
    i_rst_n = 1'b1;

    // Acquisition: peak at phase 5
    shp = '{10, 10, 10, 10, 10, 1000, 10, 10};
    send_win(0);
    chk("acq_phase", 32'(o_phase), 5);
    chk("acq_lock",  32'(o_lock),  1);
    chk("acq_model_phase", 32'(m_phase), 5);

    // Asynchronous reset in the middle of a window
    repeat (5) send_sym(1'($urandom_range(1, 0)), 0);
    #1 i_rst_n = 1'b0;
    #1;
    chk("async_rst_phase", 32'(o_phase), 0);
    chk("async_rst_lock",  32'(o_lock),  0);
    chk("async_rst_valid", 32'(o_valid), 0);
    @(negedge clk);
    #1 i_rst_n = 1'b1;

    // Phase move 2 -> 6
    shp = '{50, 300, 1000, 300, 50, 20, 10, 10};
    send_win(20);
    chk("move_lock_phase", 32'(o_phase), 2);
    chk("move_model_phase", 32'(m_phase), 2);
    send_win(20);
    shp = '{10, 10, 20, 50, 300, 300, 1000, 50};
    vcnt = 0; cnt_on = 1'b1;
    send_win(20);
    chk("move_new_phase", 32'(o_phase), 6);
    send_win(20);
    cnt_on = 1'b0;
    chk("move_valid_count", 32'(vcnt), 32);

    // All-equal energies pick phase 0
    shp = '{200, 200, 200, 200, 200, 200, 200, 200};
    send_win(0);
    chk("tie_phase0", 32'(o_phase), 0);

    // |-4096| clamps to 4095, tying phase 1 (+4095) -> lower index wins
    for (int s = 0; s < WIN; s++) begin
      cur_tx_bit = 1'b0;
      for (int ph = 0; ph < OS; ph++)
        sample((s == 0 && ph == 1) ? 4095 : ((s == 0 && ph == 2) ? -4096 : 0));
    end
    chk("abs_clamp_phase", 32'(o_phase), 1);

    // Saturation: every accumulator pins at all-ones, so phase 0 wins
    shp = '{3000, 3000, 3000, 4095, 3000, 3000, 3000, 3000};
    send_win(0);
    chk("sat_phase", 32'(o_phase), 0);
    shp = '{10, 10, 10, 10, 900, 10, 10, 10};
    send_win(10);
    chk("post_sat_phase", 32'(o_phase), 4);

    // Loopback PRBS7 through a pulse shape, first gapless then with stalls
    shp = '{80, 200, 500, 900, 600, 300, 150, 60};
    loop_on = 1'b1;
    repeat (250) send_sym(prbs_next(), 30);
    gap_max = 5;
    repeat (300) send_sym(prbs_next(), 30);
    gap_max = 0;
    tick(1'b0, 1'b0, '0);
    loop_on = 1'b0;
    chk("loop_errors", 32'(loop_errs), 0);
    chk("loop_bits",   32'(loop_bits), 550);
    chk("loop_phase",  32'(o_phase),   3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
